// File: rtl/ram_copy_master.sv
// Word-by-word RAM-to-RAM copy engine driving a single-port RAM with combinational read.
// Each word takes one READ and one WRITE cycle; a running checksum of copied words is kept.
module ram_copy_master #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DEPTH-1:0] src_addr,
    input  logic [DEPTH-1:0] dst_addr,
    input  logic [DEPTH:0]   length,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] checksum,
    output logic             ram_ena,
    output logic             wena,
    output logic [DEPTH-1:0] addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    localparam logic [DEPTH:0] LEN_ONE = 1;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] src_q, src_d;
    logic [DEPTH-1:0] dst_q, dst_d;
    logic [DEPTH:0]   len_q, len_d;
    logic [DEPTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] cks_q, cks_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ena_q, ena_d;
    logic             wena_q, wena_d;
    logic [DEPTH-1:0] addr_q, addr_d;

    // Outputs are registered, so each transition sets up the RAM controls for the state being entered.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cks_d   = cks_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ena_d   = ena_q;
        wena_d  = wena_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    len_d = length;
                    idx_d = '0;
                    cks_d = '0;
                    if (length == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                        busy_d  = 1'b1;
                        ena_d   = 1'b1;
                        wena_d  = 1'b0;
                        addr_d  = src_addr;
                    end
                end
            end
            READ: begin
                buf_d   = ram_rdata;
                cks_d   = cks_q + ram_rdata;
                state_d = WRITE;
                wena_d  = 1'b1;
                addr_d  = dst_q + idx_q;
            end
            WRITE: begin
                if ({1'b0, idx_q} == len_q - LEN_ONE) begin
                    state_d = FIN;
                    busy_d  = 1'b0;
                    ena_d   = 1'b0;
                    wena_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = READ;
                    wena_d  = 1'b0;
                    addr_d  = src_q + idx_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            cks_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ena_q   <= 1'b0;
            wena_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            cks_q   <= cks_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ena_q   <= ena_d;
            wena_q  <= wena_d;
            addr_q  <= addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = cks_q;
    assign ram_ena   = ena_q;
    assign wena      = wena_q;
    assign addr      = addr_q;
    assign ram_wdata = buf_q;

endmodule

// File: doc/ram_copy_master.md
RAM_COPY_MASTER -- requirements
Module: ram_copy_master

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the RAM data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 3, giving the RAM address width; memory holds 2**DEPTH words.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, a copy request that is sampled only in IDLE.
REQ-006 The block SHALL have port src_addr, input, DEPTH, the first source word address, captured on start acceptance.
REQ-007 The block SHALL have port dst_addr, input, DEPTH, the first destination word address, captured on start acceptance.
REQ-008 The block SHALL have port length, input, DEPTH+1, the word count 0..2**DEPTH, captured on start acceptance.
REQ-009 The block SHALL have port busy, output, 1, which is high while a copy is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 The block SHALL have port checksum, output, WIDTH, the modulo-2**WIDTH sum of the words copied by the last operation.
REQ-012 The block SHALL have port ram_ena, output, 1, which drives the RAM enable.
REQ-013 The block SHALL have port wena, output, 1, which drives the RAM write enable.
REQ-014 The block SHALL have port addr, output, DEPTH, which drives the RAM address.
REQ-015 The block SHALL have port ram_wdata, output, WIDTH, which drives the RAM data_in.
REQ-016 The block SHALL have port ram_rdata, input, WIDTH, fed from the RAM data_out; the read is combinational (data valid in the same cycle as addr).

Function
REQ-017 The FSM SHALL have four states: IDLE, READ, WRITE and FIN.
REQ-018 In IDLE, start=1 SHALL capture src_addr, dst_addr and length, clear the word index idx and checksum to 0, and go to READ; if length==0 it SHALL go directly to FIN with no RAM access.
REQ-019 In READ, the block SHALL drive ram_ena=1, wena=0 and addr=src+idx (mod 2**DEPTH), register ram_rdata into buffer at the clock edge, add it to checksum, and go to WRITE.
REQ-020 In WRITE, the block SHALL drive ram_ena=1, wena=1, addr=dst+idx (mod 2**DEPTH) and ram_wdata=buffer; then, if idx==length-1, it SHALL go to FIN, else increment idx and go to READ.
REQ-021 In FIN, the block SHALL assert done=1 for exactly one cycle and go to IDLE.
REQ-022 busy SHALL be 1 in READ and WRITE only; done SHALL be 1 in FIN only.
REQ-023 In IDLE and FIN, the block SHALL drive ram_ena=0 and wena=0, hold addr at its last value, and drive ram_wdata as buffer.
REQ-024 Per-copy latency SHALL be: start accepted at cycle 0, READ/WRITE occupying cycles 1..2*length, and done at cycle 2*length+1; for length==0, done SHALL occur at cycle 1.
REQ-025 Address arithmetic SHALL wrap modulo 2**DEPTH; a range crossing the top address SHALL continue at 0.
REQ-026 The copy SHALL be strictly forward, word by word; overlapping ranges SHALL yield the result of sequential read-then-write per word, with no special handling.
REQ-027 start SHALL be ignored while in READ, WRITE or FIN; no request queueing.
REQ-028 length values above 2**DEPTH SHALL be impossible by width; length==2**DEPTH SHALL copy every word once.
REQ-029 checksum SHALL hold its value after FIN until the next accepted start.

Reset
REQ-030 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and set busy=0, done=0, ram_ena=0, wena=0, addr=0, buffer=0 and checksum=0.
REQ-031 Reset asserted mid-copy SHALL abort immediately with no further RAM access and no done pulse; partially written words SHALL remain in the RAM.

Verification
REQ-032 The bench SHALL cover a basic copy: RAM[0..2]=11,22,33; start with src=0, dst=4, len=3 -> RAM[4..6]=11,22,33, done at cycle 7, checksum=0x66, busy high for cycles 1..6.
REQ-033 The bench SHALL cover wrap-around: src=6, dst=1, len=4 with RAM[6,7,0,1]=A,B,C,D -> reads 6,7,0,1, writes 1,2,3,4 in that order; trace the addr sequence and the overlapping write to word 1.
REQ-034 The bench SHALL cover zero length: len=0 -> done pulse at cycle 1, ram_ena never asserted, checksum=0.
REQ-035 The bench SHALL cover start while busy: a second start pulse during a copy -> ignored; exactly one done; captured parameters unchanged.
REQ-036 The bench SHALL cover reset mid-copy: rst_n=0 at cycle 3 of a len=3 copy -> next cycle IDLE, all outputs at reset values, only RAM[dst] written, no done.
REQ-037 The bench SHALL cover a full-memory checksum: len=8 with src=dst=0 and RAM=0xFF in all words -> RAM unchanged, checksum=0xF8, done at cycle 17.
